// File: rtl/commit_stage_pkg.sv
// Shared types for the retire stage: commit entry layout, FSM states,
// machine-mode cause codes and the exception-to-cause mapping.
package commit_stage_pkg;

  localparam int CS_XLEN = 32;

  localparam logic [CS_XLEN-1:0] MCAUSE_ILLEGAL_INSTR = CS_XLEN'(2);
  localparam logic [CS_XLEN-1:0] MCAUSE_BREAKPOINT    = CS_XLEN'(3);
  localparam logic [CS_XLEN-1:0] MCAUSE_M_ECALL       = CS_XLEN'(11);

  // Exception kinds reported by the execution units
  typedef enum logic [1:0] {
    EX_ILLEGAL_INSTR = 2'd0,
    EX_BREAKPOINT    = 2'd1,
    EX_M_ECALL       = 2'd2
  } ex_type_t;

  typedef struct packed {
    logic [4:0]         rd_idx;
    logic [CS_XLEN-1:0] rd_val;
    logic               br_valid;
    logic [CS_XLEN-1:0] br_target;
    logic               ret_valid;
    logic               ex_valid;
    ex_type_t           ex_type;
  } exec_result_t;

  typedef struct packed {
    logic [CS_XLEN-1:0] pc;
    exec_result_t       res;
  } commit_entry;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } commit_state_t;

  // Interrupt bit is never set: only synchronous exceptions reach this stage.
  // Unknown encodings are reported as illegal instructions.
  function automatic logic [CS_XLEN-1:0] cause_code(input ex_type_t ex);
    case (ex)
      EX_BREAKPOINT: cause_code = MCAUSE_BREAKPOINT;
      EX_M_ECALL:    cause_code = MCAUSE_M_ECALL;
      default:       cause_code = MCAUSE_ILLEGAL_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/commit_stage.sv
// Retire stage: register-file writeback, M-mode trap/MRET handling,
// branch/trap redirect with flush, and the minstret counter.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [31:0] MEPC_RESET = 32'h0,
  parameter int          PIPE_DRAIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            entry_valid_i,
  output logic            entry_ready_o,
  input  logic [XLEN-1:0] entry_pc_i,
  input  logic [4:0]      entry_rd_idx_i,
  input  logic [XLEN-1:0] entry_rd_val_i,
  input  logic            entry_br_valid_i,
  input  logic [XLEN-1:0] entry_br_target_i,
  input  logic            entry_ret_valid_i,
  input  logic            entry_ex_valid_i,
  input  logic [1:0]      entry_ex_type_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_target_o,
  output logic            flush_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [63:0]     minstret_o
);

  localparam int CW = $clog2(PIPE_DRAIN + 1);
  localparam logic [CW-1:0] DRAIN_INIT = CW'(PIPE_DRAIN - 1);
  localparam logic [CW-1:0] DRAIN_ONE  = CW'(1);

  commit_entry   ent;
  commit_state_t state_q;
  logic [CW-1:0] drain_q;
  logic          redir_q;
  logic [XLEN-1:0] target_q;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     minstret_q, minstret_d;

  logic fire, do_trap, do_ret, do_br, do_redir;

  assign ent = '{pc: entry_pc_i,
                 res: '{rd_idx:    entry_rd_idx_i,
                        rd_val:    entry_rd_val_i,
                        br_valid:  entry_br_valid_i,
                        br_target: entry_br_target_i,
                        ret_valid: entry_ret_valid_i,
                        ex_valid:  entry_ex_valid_i,
                        ex_type:   ex_type_t'(entry_ex_type_i)}};

  assign entry_ready_o = (state_q == ST_RUN);
  assign fire          = entry_valid_i && entry_ready_o;

  // A trap wins over MRET, which wins over a taken branch
  assign do_trap  = fire && ent.res.ex_valid;
  assign do_ret   = fire && !ent.res.ex_valid && ent.res.ret_valid;
  assign do_br    = fire && !ent.res.ex_valid && !ent.res.ret_valid && ent.res.br_valid;
  assign do_redir = do_trap || do_ret || do_br;

  // Next-state for writeback, CSRs and the retire counter
  always_comb begin
    rf_we_d    = fire && !ent.res.ex_valid && !ent.res.ret_valid && (ent.res.rd_idx != 5'd0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    minstret_d = minstret_q;
    if (rf_we_d) begin
      rf_waddr_d = ent.res.rd_idx;
      rf_wdata_d = ent.res.rd_val;
    end
    if (do_trap) begin
      mepc_d   = ent.pc;
      mcause_d = cause_code(ent.res.ex_type);
    end
    if (fire && !ent.res.ex_valid) minstret_d = minstret_q + 64'd1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mepc_q     <= MEPC_RESET;
      mcause_q   <= '0;
      minstret_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      minstret_q <= minstret_d;
    end
  end

  // Redirect FSM: strobe in the first REDIRECT cycle, then drain before accepting again
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      redir_q  <= 1'b0;
      target_q <= '0;
    end else begin
      redir_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (do_redir) begin
            state_q <= ST_REDIRECT;
            drain_q <= DRAIN_INIT;
            redir_q <= 1'b1;
            if (do_trap)     target_q <= {mtvec_i[XLEN-1:2], 2'b00};
            else if (do_ret) target_q <= mepc_q;
            else             target_q <= ent.res.br_target;
          end
        end
        default: begin
          if (drain_q == '0) state_q <= ST_RUN;
          else               drain_q <= drain_q - DRAIN_ONE;
        end
      endcase
    end
  end

  assign rf_we_o           = rf_we_q;
  assign rf_waddr_o        = rf_waddr_q;
  assign rf_wdata_o        = rf_wdata_q;
  assign redirect_valid_o  = redir_q;
  assign flush_o           = redir_q;
  assign redirect_target_o = target_q;
  assign mepc_o            = mepc_q;
  assign mcause_o          = mcause_q;
  assign minstret_o        = minstret_q;

endmodule
